// File: rtl/jpeg_cone_pkg.sv
// Shared definitions for the JPEG timing-cone evaluator.
// Holds the default lane count, the pipeline latency and the
// lane-generic AOI cone function y = ~((n0 & n1 & n2) | (n3 & n4)).
package jpeg_cone_pkg;

  localparam int unsigned LANES_DEFAULT = 4;
  localparam int unsigned LANES_MAX     = 64;
  localparam int unsigned LAT           = 2;

  // Evaluated at the widest lane count; callers zero-extend and truncate.
  function automatic logic [LANES_MAX-1:0] cone_aoi32(
    input logic [LANES_MAX-1:0] n0,
    input logic [LANES_MAX-1:0] n1,
    input logic [LANES_MAX-1:0] n2,
    input logic [LANES_MAX-1:0] n3,
    input logic [LANES_MAX-1:0] n4
  );
    return ~((n0 & n1 & n2) | (n3 & n4));
  endfunction

endpackage

// File: rtl/jpeg_cone_pipe_stage.sv
// Generic elastic valid/ready register stage.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   valid_i/data_i    upstream payload
//   ready_c_o         combinational ready to upstream (~valid | ready_i)
//   valid_o/data_o    registered payload to downstream
//   ready_i           downstream ready
module jpeg_cone_pipe_stage #(
  parameter int unsigned W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_c_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         load_c;

  // Accept when empty or when the current content leaves this cycle.
  always_comb begin
    ready_c_o = ~valid_q | ready_i;
    load_c    = valid_i & ready_c_o;
    valid_d   = load_c | (valid_q & ~ready_i);
    data_d    = load_c ? data_i : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/jpeg_cone_eval_pipe.sv
// Two-stage elastic multi-lane AOI cone evaluator.
// S1 registers p = n0&n1&n2 and q = n3&n4; S2 registers y = ~(p|q).
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   in_valid/in_ready          input handshake (in_ready combinational)
//   in_n0..in_n4               per-lane operands, bit i is lane i
//   out_valid/out_ready/out_y  output handshake and result
//   stat_low_cnt               saturating count of retired results with a
//                              low lane (only with CONE_EVAL_STATS_EN)
// Build option: CONE_EVAL_STATS_EN adds the statistics counter and port.
module jpeg_cone_eval_pipe
  import jpeg_cone_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEFAULT,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] in_n0,
  input  logic [LANES-1:0] in_n1,
  input  logic [LANES-1:0] in_n2,
  input  logic [LANES-1:0] in_n3,
  input  logic [LANES-1:0] in_n4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] out_y
`ifdef CONE_EVAL_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_low_cnt
`endif
);

  localparam int unsigned PW = 2 * LANES;

  if (LANES < 1 || LANES > LANES_MAX || CNT_W < 1) begin : g_param_err
    $error("jpeg_cone_eval_pipe: LANES must be 1..64 and CNT_W >= 1");
  end

  logic [PW-1:0]        s1_in_c;
  logic [PW-1:0]        s1_data;
  logic                 s1_valid;
  logic                 s2_ready_c;
  logic [LANES-1:0]     p_c, q_c, y_c;
  logic [LANES_MAX-1:0] ones_c;

  assign s1_in_c = {in_n0 & in_n1 & in_n2, in_n3 & in_n4};
  assign ones_c  = '1;

  jpeg_cone_pipe_stage #(
    .W       (PW),
    .RST_VAL ('0)
  ) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (in_valid),
    .ready_c_o (in_ready),
    .data_i    (s1_in_c),
    .valid_o   (s1_valid),
    .ready_i   (s2_ready_c),
    .data_o    (s1_data)
  );

  // With the AND3 operands pinned high the cone collapses to NOR2(p, q).
  assign {p_c, q_c} = s1_data;
  assign y_c = LANES'(cone_aoi32(LANES_MAX'(p_c), ones_c, ones_c,
                                 LANES_MAX'(q_c), ones_c));

  jpeg_cone_pipe_stage #(
    .W       (LANES),
    .RST_VAL ('1)
  ) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (s1_valid),
    .ready_c_o (s2_ready_c),
    .data_i    (y_c),
    .valid_o   (out_valid),
    .ready_i   (out_ready),
    .data_o    (out_y)
  );

`ifdef CONE_EVAL_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of retired results with any lane low.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && !(&out_y) && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stat_low_cnt = cnt_q;
`endif

endmodule

// File: doc/jpeg_cone_eval_pipe.md
# jpeg_cone_eval_pipe

Pipelined, multi-lane evaluator for the JPEG timing-cone AOI function. For each lane it computes y = ~((n0 & n1 & n2) | (n3 & n4)) over LANES independent bit-lanes. The result passes through a two-stage elastic valid/ready pipeline, so the cone can sit between registered producers and consumers in the timing-cone test harness at full throughput. An optional statistics counter records how many transactions drove at least one lane low.

## Interface
Parameters:
- LANES, default 4, number of independent cone lanes (1..64).
- CNT_W, default 16, width of the statistics counter (used only when the stats feature is compiled in).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  producer presents a transaction.
- in_ready  output  1  block accepts the transaction this cycle.
- in_n0, in_n1, in_n2  input  LANES  AND3 term operands, bit i belongs to lane i.
- in_n3, in_n4  input  LANES  AND2 term operands.
- out_valid  output  1  out_y holds a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- out_y  output  LANES  per-lane result.
- stat_low_cnt  output  CNT_W  count of retired transactions with any out_y bit equal to 0 (present only with CONE_EVAL_STATS_EN).

## Operation
- Handshake: a transfer occurs when valid & ready are both high on a clk edge. This applies to both the input and the output side.
- Stage 1 (S1): on input transfer, register p = n0 & n1 & n2 and q = n3 & n4, both LANES wide, and set s1_valid.
- Stage 2 (S2): when S1 advances, register out_y = ~(p | q) and set s2_valid. out_valid = s2_valid.
- Advance rules:
  - S2 loads when s1_valid & (~s2_valid | out_ready).
  - S1 loads when in_valid & in_ready.
  - in_ready = ~s1_valid | ~s2_valid | out_ready. This is combinational and gives no bubbles at steady state.
- A stage whose valid is 0 and which is not loaded keeps its data unchanged. Its contents are don't-care but must not produce X on out_y after reset.
- Backpressure: while out_valid & ~out_ready, out_y must stay stable. When both stages are full, in_ready = 0.
- Simultaneous events:
  - An output retire and an S1→S2 move in the same cycle leave s2_valid at 1 with the new data.
  - An input accept while S1 is emptying refills S1 in the same edge.
- Reset values: s1_valid = 0, s2_valid = 0, out_valid = 0, out_y = all ones, stat_low_cnt = 0. in_ready is therefore 1 in the first cycle after reset.
- Reset mid-operation drops all in-flight transactions. No output transfer occurs on the reset edge.

## Timing
- Latency: 2 cycles from input transfer to out_valid, with no stall.
- Throughput: 1 transaction per cycle while out_ready is held high.
- in_ready is the only combinational path from out_ready. No combinational path exists from in_* to out_*.
- Each S1 lane is an AND3/AND2, and each S2 lane is a NOR2. Both stages fit one cycle by construction.

## Configuration
- Macro: CONE_EVAL_STATS_EN.
- Defined:
  - The stat_low_cnt port and counter exist.
  - The counter increments by 1 on every output transfer where out_y != all ones.
  - It saturates at 2^CNT_W−1 rather than wrapping.
  - It clears only on rst.
- Undefined: the port and counter are absent, and the datapath is identical.

## Structure
- Shared package jpeg_cone_pkg holds:
  - the cone function as a LANES-generic function cone_aoi32(n0..n4);
  - localparam LAT = 2;
  - the default LANES.
- One sub-module, jpeg_cone_pipe_stage: a generic valid/ready register stage with parameter W. It is instantiated twice, with payload {p,q} of width 2·LANES and payload y of width LANES.

## Test plan
- Reset then idle: assert rst for 2 cycles. Expect out_valid = 0, out_y = 4'b1111, in_ready = 1, stat_low_cnt = 0.
- Single transfer, LANES = 4: n0 = n1 = n2 = 4'b0011, n3 = 4'b0100, n4 = 4'b0110, out_ready = 1. Expect out_y = 4'b1000 exactly 2 cycles later, and stat_low_cnt = 1.
- Streaming: 16 back-to-back random vectors with out_ready = 1. Expect 16 results in order, matching the model, with no bubbles and in_ready constantly 1.
- Backpressure: out_ready = 0 for 5 cycles while feeding. Expect in_ready to drop after 2 accepts, out_y held stable, and no loss or duplication after out_ready returns to 1.
- Mid-stream reset: reset with both stages full. Expect out_valid = 0 next cycle, the old data never appears, and the counter is cleared.
- Saturation, with CONE_EVAL_STATS_EN defined and CNT_W = 2: 5 transactions, each with a low lane. Expect stat_low_cnt to stop at 3.
